accum_window: RTL and testbench

- Parametrised, two-stage registered accumulator; next generation of the 8-bit lab accumulator.
- Adds these features:
  - configurable width;
  - add/subtract per sample;
  - signed or unsigned overflow semantics;
  - optional saturation;
  - valid qualification and synchronous clear;
  - fixed-length accumulation windows with a held result and a done pulse.
- Sits between a sample source (switches/ADC model) and display/result logic.

---
 rtl/accum_window.sv | 162 ++++++++++++++++
 tb/tb_accum_window.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_window.sv
// accum_window: two-stage registered accumulator with add/subtract per sample,
// signed or unsigned overflow rules, optional saturation, synchronous clear
// and fixed-length accumulation windows that publish a held result.
//
// Stage 1 registers the incoming sample (a, sub, in_valid).
// Stage 2 folds the registered sample into the running sum.
// After DEPTH accumulated samples, stage 2 copies the final sum into result,
// pulses done for one cycle, and restarts the window from zero.

module accum_window #(
   parameter int WIDTH    = 8,   // datapath width of a, sum and result
   parameter int DEPTH    = 4,   // samples per accumulation window (>= 2)
   parameter int SIGNED   = 1,   // 1: two's-complement overflow rules
   parameter int SATURATE = 0    // 1: clamp on overflow, 0: wrap
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         a,
   input  logic                     sub,
   output logic [WIDTH-1:0]         a_reg,
   output logic                     a_valid,
   output logic [WIDTH-1:0]         sum,
   output logic                     c,
   output logic                     v,
   output logic                     v_sticky,
   output logic [$clog2(DEPTH)-1:0] count,
   output logic [WIDTH-1:0]         result,
   output logic                     result_ovf,
   output logic                     done
);

   localparam int CW = $clog2(DEPTH);

   // count value of the sample that closes a window
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEPTH - 1);

   // saturation limits
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   // registered subtract flag travelling alongside a_reg
   logic             sub_q;

   // one-bit-wider raw results; the extra MSB is carry (add) or borrow (sub)
   logic [WIDTH:0]   raw_add;
   logic [WIDTH:0]   raw_sub;
   logic [WIDTH:0]   raw_next;

   // status of the step that would be applied on the next accumulate edge
   logic             carry_next;
   logic             ovf_next;
   logic [WIDTH-1:0] sum_next;
   logic             last_sample;

   // raw add/subtract of the registered sample against the running sum
   always_comb begin
      raw_add    = {1'b0, sum} + {1'b0, a_reg};
      raw_sub    = {1'b0, sum} - {1'b0, a_reg};
      raw_next   = sub_q ? raw_sub : raw_add;
      // For subtraction the wrapped MSB is set exactly when a_reg > sum,
      // which is the unsigned borrow.
      carry_next = raw_next[WIDTH];
   end

   // Overflow detection depends on the number interpretation.
   generate
      if (SIGNED != 0) begin : g_ovf_signed
         // add: operands share a sign and the result sign flips
         // sub: operands differ in sign and the result sign leaves sum's sign
         assign ovf_next = sub_q
            ? ((sum[WIDTH-1] != a_reg[WIDTH-1]) && (raw_next[WIDTH-1] != sum[WIDTH-1]))
            : ((sum[WIDTH-1] == a_reg[WIDTH-1]) && (raw_next[WIDTH-1] != sum[WIDTH-1]));
      end else begin : g_ovf_unsigned
         // unsigned overflow is simply the carry/borrow out
         assign ovf_next = carry_next;
      end
   endgenerate

   // Saturating or wrapping result of the step.
   generate
      if (SATURATE != 0) begin : g_saturate
         // Signed clamp direction follows the sign of the sum operand: an
         // overflow can only push the sum further in the direction it already
         // leans. Unsigned clamps high on carry and low on borrow.
         assign sum_next = !ovf_next ? raw_next[WIDTH-1:0]
                         : (SIGNED != 0) ? (sum[WIDTH-1] ? NEG_MIN : POS_MAX)
                         : (sub_q ? {WIDTH{1'b0}} : ALL_ONES);
      end else begin : g_wrap
         // modulo 2^WIDTH: drop the carry bit
         assign sum_next = raw_next[WIDTH-1:0];
      end
   endgenerate

   // this accumulate step closes the current window
   assign last_sample = a_valid && (count == LAST_COUNT);

   // Stage 1: capture the sample every edge; only a_valid qualifies it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_reg   <= '0;
         sub_q   <= 1'b0;
         a_valid <= 1'b0;
      end else begin
         a_reg   <= a;
         sub_q   <= sub;
         // a clear discards the sample arriving in the same cycle
         a_valid <= in_valid && !clear;
      end
   end

   // Stage 2: accumulate qualified samples and roll over at window end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum      <= '0;
         c        <= 1'b0;
         v        <= 1'b0;
         v_sticky <= 1'b0;
         count    <= '0;
      end else if (clear) begin
         sum      <= '0;
         c        <= 1'b0;
         v        <= 1'b0;
         v_sticky <= 1'b0;
         count    <= '0;
      end else if (a_valid) begin
         // c and v always describe the step just taken, including the last
         c <= carry_next;
         v <= ovf_next;
         if (last_sample) begin
            sum      <= '0;
            count    <= '0;
            v_sticky <= 1'b0;
         end else begin
            sum      <= sum_next;
            count    <= count + CW'(1);
            v_sticky <= v_sticky | ovf_next;
         end
      end
   end

   // Window result: held between completions, one-cycle done pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result     <= '0;
         result_ovf <= 1'b0;
         done       <= 1'b0;
      end else if (clear) begin
         // clear beats a completing sample: result stays, no pulse
         done <= 1'b0;
      end else if (last_sample) begin
         result     <= sum_next;
         result_ovf <= v_sticky | ovf_next;
         done       <= 1'b1;
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_accum_window.sv
// tb_accum_window: runs four accum_window instances (signed/unsigned x
// wrap/saturate, WIDTH 8, DEPTH 4) from shared stimulus. Directed scenarios
// come first, then a randomized run. Every output is compared each cycle
// against an integer-arithmetic reference model of the window accumulator.

module tb_accum_window;

   localparam int W = 8;
   localparam int D = 4;
   localparam int N = 4;   // instance i: SIGNED = (i < 2), SATURATE = i % 2

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       clear    = 1'b0;
   logic       in_valid = 1'b0;
   logic       sub      = 1'b0;
   logic [7:0] a        = 8'h00;

   logic [7:0] a_reg_w  [N];
   logic [7:0] sum_w    [N];
   logic [7:0] result_w [N];
   logic [1:0] count_w  [N];
   logic       a_valid_w[N];
   logic       c_w      [N];
   logic       v_w      [N];
   logic       vs_w     [N];
   logic       rovf_w   [N];
   logic       done_w   [N];

   int errors = 0;
   int checks = 0;
   int nstep  = 0;

   // reference model state
   int m_sum [N];
   int m_c   [N];
   int m_v   [N];
   int m_vs  [N];
   int m_cnt [N];
   int m_res [N];
   int m_rovf[N];
   int m_done[N];
   int m_a, m_av, m_sub;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dut
         accum_window #(
            .WIDTH(W), .DEPTH(D), .SIGNED((gi < 2) ? 1 : 0), .SATURATE(gi % 2)
         ) u_dut (
            .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
            .a(a), .sub(sub), .a_reg(a_reg_w[gi]), .a_valid(a_valid_w[gi]),
            .sum(sum_w[gi]), .c(c_w[gi]), .v(v_w[gi]), .v_sticky(vs_w[gi]),
            .count(count_w[gi]), .result(result_w[gi]),
            .result_ovf(rovf_w[gi]), .done(done_w[gi])
         );
      end
   endgenerate

   // single comparison point for the whole bench
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_sum[i] = 0; m_c[i] = 0; m_v[i] = 0; m_vs[i] = 0;
         m_cnt[i] = 0; m_res[i] = 0; m_rovf[i] = 0; m_done[i] = 0;
      end
      m_a = 0; m_av = 0; m_sub = 0;
   endfunction

   // One clock edge of the reference: integer arithmetic on the true values,
   // overflow judged by range, then wrap or clamp.
   function automatic void model_edge(input int clr, input int vld, input int av, input int sb);
      int us, ua, ut, ss, sa, st, cy, ovf, ns, vsn;
      for (int i = 0; i < N; i++) begin
         if (clr != 0) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_c[i] = 0; m_v[i] = 0;
            m_vs[i] = 0; m_done[i] = 0;
         end else begin
            m_done[i] = 0;
            if (m_av != 0) begin
               us = m_sum[i];
               ua = m_a;
               ut = (m_sub != 0) ? us - ua : us + ua;
               cy = (ut < 0 || ut > 255) ? 1 : 0;
               ss = (us >= 128) ? us - 256 : us;
               sa = (ua >= 128) ? ua - 256 : ua;
               st = (m_sub != 0) ? ss - sa : ss + sa;
               ovf = (i < 2) ? ((st > 127 || st < -128) ? 1 : 0) : cy;
               if ((i % 2) == 1 && ovf != 0) begin
                  if (i < 2) ns = (ss < 0) ? 128 : 127;
                  else       ns = (m_sub != 0) ? 0 : 255;
               end else begin
                  ns = ut & 255;
               end
               m_c[i] = cy;
               m_v[i] = ovf;
               vsn = m_vs[i] | ovf;
               if (m_cnt[i] == D - 1) begin
                  m_res[i] = ns; m_rovf[i] = vsn; m_done[i] = 1;
                  m_sum[i] = 0; m_cnt[i] = 0; m_vs[i] = 0;
               end else begin
                  m_sum[i] = ns; m_cnt[i] = m_cnt[i] + 1; m_vs[i] = vsn;
               end
            end
         end
      end
      m_a = av; m_sub = sb; m_av = (clr != 0) ? 0 : vld;
   endfunction

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("u%0d.a_reg", i),      a_reg_w[i],   m_a);
         chk($sformatf("u%0d.a_valid", i),    a_valid_w[i], m_av);
         chk($sformatf("u%0d.sum", i),        sum_w[i],     m_sum[i]);
         chk($sformatf("u%0d.c", i),          c_w[i],       m_c[i]);
         chk($sformatf("u%0d.v", i),          v_w[i],       m_v[i]);
         chk($sformatf("u%0d.v_sticky", i),   vs_w[i],      m_vs[i]);
         chk($sformatf("u%0d.count", i),      count_w[i],   m_cnt[i]);
         chk($sformatf("u%0d.result", i),     result_w[i],  m_res[i]);
         chk($sformatf("u%0d.result_ovf", i), rovf_w[i],    m_rovf[i]);
         chk($sformatf("u%0d.done", i),       done_w[i],    m_done[i]);
      end
   endtask

   // one transaction: drive inputs, take one edge, update model, compare
   task automatic step(input logic clr, input logic vld, input logic [7:0] av, input logic sb);
      clear = clr; in_valid = vld; a = av; sub = sb;
      @(posedge clk);
      model_edge(int'(clr), int'(vld), int'(av), int'(sb));
      #1;
      check_all();
      nstep++;
      $display("step %0d clr=%0b vld=%0b a=%02h sub=%0b | sum=%02h/%02h/%02h/%02h done=%0b result=%02h",
               nstep, clr, vld, av, sb, sum_w[0], sum_w[1], sum_w[2], sum_w[3],
               done_w[0], result_w[0]);
   endtask

   // asynchronous reset between edges; outputs must clear before the next edge
   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      $display("async reset at %0t", $time);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      model_reset();
      in_valid = 1'b1; a = 8'h33;   // activity while held in reset
      #12;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 8'h00, 0);

      // signed wrap / saturate: 0x50 + 0x50
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h50, 0);
      step(0, 1, 8'h50, 0);
      chk("wrap.first_sum", sum_w[0], 8'h50);
      step(0, 0, 8'h00, 0);
      chk("wrap.sum", sum_w[0], 8'hA0);
      chk("wrap.v", v_w[0], 1);
      chk("wrap.c", c_w[0], 0);
      chk("wrap.v_sticky", vs_w[0], 1);
      chk("sat.sum", sum_w[1], 8'h7F);
      chk("sat.v", v_w[1], 1);
      step(0, 1, 8'h01, 1);
      step(0, 0, 8'h00, 0);
      chk("sat.sub_sum", sum_w[1], 8'h7E);
      chk("sat.sub_v", v_w[1], 0);
      chk("sat.sub_v_sticky", vs_w[1], 1);

      // unsigned borrow: 5 - 7
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h05, 0);
      step(0, 1, 8'h07, 1);
      step(0, 0, 8'h00, 0);
      chk("borrow.sum", sum_w[2], 8'hFE);
      chk("borrow.c", c_w[2], 1);
      chk("borrow.v", v_w[2], 1);
      chk("borrow.sat_sum", sum_w[3], 8'h00);

      // window of 1,2,3,4 back-to-back
      step(1, 0, 8'h00, 0);
      for (int k = 1; k <= 4; k++) step(0, 1, 8'(k), 0);
      chk("win.no_done_early", done_w[0], 0);
      step(0, 0, 8'h00, 0);
      chk("win.done", done_w[0], 1);
      chk("win.result", result_w[0], 8'h0A);
      chk("win.sum", sum_w[0], 8'h00);
      chk("win.count", count_w[0], 2'd0);
      step(0, 0, 8'h00, 0);
      chk("win.done_drop", done_w[0], 0);

      // gapped window: done follows the edge after the 4th capture
      for (int k = 1; k <= 4; k++) begin
         step(0, 1, 8'(k), 0);
         step(0, 0, 8'h00, 0);
         if (k == 3) chk("gap.no_done", done_w[0], 0);
      end
      chk("gap.done", done_w[0], 1);
      chk("gap.result", result_w[0], 8'h0A);

      // clear on the completing edge
      for (int k = 1; k <= 4; k++) step(0, 1, 8'h05, 0);
      step(1, 0, 8'h00, 0);
      chk("clrcol.done", done_w[0], 0);
      chk("clrcol.result", result_w[0], 8'h0A);
      chk("clrcol.sum", sum_w[0], 8'h00);

      // clear with an incoming sample discards it
      step(1, 1, 8'h09, 0);
      chk("clrin.a_valid", a_valid_w[0], 0);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      chk("clrin.sum", sum_w[0], 8'h00);
      chk("clrin.count", count_w[0], 2'd0);

      // mid-window asynchronous reset
      step(0, 1, 8'h11, 0);
      step(0, 1, 8'h22, 0);
      step(0, 1, 8'h33, 0);
      async_reset();
      step(0, 0, 8'h00, 0);

      // randomized run
      for (int r = 0; r < 300; r++) begin
         if (r == 150) async_reset();
         step(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              8'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
